// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers raster position from hsync/vsync, checks line
// and frame timing, locks after clean frames and emits visible pixels.
module vga_sync_receiver #(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       vga_clk,
    input  logic       rst_n,
    input  logic [2:0] rgb_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic       locked,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [2:0] pix_rgb,
    output logic       line_err,
    output logic       frame_err,
    output logic [7:0] err_count
);

    localparam int WD_W = $clog2(2 * H_TOTAL + 1);
    localparam int GW   = $clog2(LOCK_FRAMES + 1);

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SW   = 11'(H_SYNC);
    localparam logic [10:0] H_VIS0 = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_VIS1 = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  H_X0   = 10'(H_SYNC + H_BACK);
    localparam logic [10:0] H_MAX  = 11'h7FF;

    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_SW   = 10'(V_SYNC);
    localparam logic [9:0]  V_VIS0 = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_VIS1 = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [9:0]  V_MAX  = 10'h3FF;

    localparam logic [WD_W-1:0] WD_MAX = WD_W'(2 * H_TOTAL);
    localparam logic [GW-1:0]   G_LAST = GW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic            r_hs;
    logic            r_vs;
    logic [2:0]      r_rgb;
    logic            r_hs_d;
    logic            r_vs_d;

    logic [10:0]     r_hpos;
    logic [10:0]     r_hwidth;
    logic            r_hseen;
    logic [WD_W-1:0] r_wd;

    logic [9:0]      r_vpos;
    logic [9:0]      r_vwidth;
    logic            r_vpend;

    state_t          r_state;
    logic [GW-1:0]   r_good;
    logic            r_bad;

    logic            r_locked;
    logic            r_pix_valid;
    logic [9:0]      r_pix_x;
    logic [9:0]      r_pix_y;
    logic [2:0]      r_pix_rgb;
    logic            r_line_err;
    logic            r_frame_err;
    logic [7:0]      r_err;

    logic            w_hfall;
    logic            w_hrise;
    logic            w_vfall;
    logic [10:0]     w_hpos;
    logic [WD_W-1:0] w_wd;
    logic            w_timeout;
    logic            w_line_bad;
    logic            w_line_err;

    logic            w_pend;
    logic            w_fstart;
    logic [9:0]      w_vpos;
    logic            w_frame_bad;
    logic            w_frame_err;

    state_t          w_state_n;
    logic [GW-1:0]   w_good_n;
    logic            w_bad_n;

    logic            w_lock_n;
    logic            w_hvis;
    logic            w_vvis;
    logic            w_pix_n;
    logic [9:0]      w_px;
    logic [9:0]      w_py;
    logic [1:0]      w_err_inc;
    logic [8:0]      w_err_sum;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs   <= 1'b0;
            r_vs   <= 1'b0;
            r_rgb  <= 3'd0;
            r_hs_d <= 1'b0;
            r_vs_d <= 1'b0;
        end else begin
            r_hs   <= hsync_in;
            r_vs   <= vsync_in;
            r_rgb  <= rgb_in;
            r_hs_d <= r_hs;
            r_vs_d <= r_vs;
        end
    end

    assign w_hfall = r_hs_d & ~r_hs;
    assign w_hrise = r_hs & ~r_hs_d;
    assign w_vfall = r_vs_d & ~r_vs;

    // w_hpos is the position of the sample currently held in r_hs/r_rgb.
    assign w_hpos = w_hfall ? 11'd0
                  : (r_hpos == H_MAX) ? r_hpos
                  : r_hpos + 11'd1;

    assign w_line_bad = (r_hpos != H_LAST) || (r_hwidth != H_SW);
    assign w_line_err = w_hfall & r_hseen & w_line_bad;

    assign w_wd = w_hfall ? '0
                : (r_wd == WD_MAX) ? r_wd
                : r_wd + 1'b1;

    // Armed only after a first hsync fall, so it fires once per outage.
    assign w_timeout = r_hseen & ~w_hfall & (w_wd == WD_MAX);

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hpos   <= 11'd0;
            r_hwidth <= 11'd0;
            r_hseen  <= 1'b0;
            r_wd     <= '0;
        end else begin
            r_hpos <= w_hpos;
            r_wd   <= w_wd;
            if (w_hfall) begin
                r_hwidth <= 11'd0;
            end else if (w_hrise) begin
                r_hwidth <= w_hpos;
            end
            if (w_timeout) begin
                r_hseen <= 1'b0;
            end else if (w_hfall) begin
                r_hseen <= 1'b1;
            end
        end
    end

    assign w_pend   = r_vpend | w_vfall;
    assign w_fstart = w_hfall & w_pend;

    assign w_vpos = w_fstart ? 10'd0
                  : !w_hfall ? r_vpos
                  : (r_vpos == V_MAX) ? r_vpos
                  : r_vpos + 10'd1;

    assign w_frame_bad = (r_vpos != V_LAST) || (r_vwidth != V_SW);
    assign w_frame_err = (w_fstart & (r_state != SEARCH) & w_frame_bad)
                       | w_timeout;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vpos   <= 10'd0;
            r_vwidth <= 10'd0;
            r_vpend  <= 1'b0;
        end else begin
            r_vpos  <= w_vpos;
            r_vpend <= w_fstart ? 1'b0 : w_pend;
            if (w_fstart) begin
                r_vwidth <= {9'd0, ~r_vs};
            end else if (w_hfall && !r_vs && r_vwidth != V_MAX) begin
                r_vwidth <= r_vwidth + 10'd1;
            end
        end
    end

    // r_bad remembers any error inside the frame being tracked.
    always_comb begin
        w_state_n = r_state;
        w_good_n  = r_good;
        w_bad_n   = r_bad | w_line_err | w_frame_err;
        unique case (r_state)
            SEARCH: begin
                if (w_fstart) begin
                    w_state_n = TRACK;
                    w_good_n  = '0;
                end
            end
            TRACK: begin
                if (w_timeout) begin
                    w_state_n = SEARCH;
                    w_good_n  = '0;
                end else if (w_fstart) begin
                    if (w_bad_n) begin
                        w_good_n = '0;
                    end else if (r_good == G_LAST) begin
                        w_state_n = LOCKED;
                        w_good_n  = '0;
                    end else begin
                        w_good_n = r_good + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (w_timeout) begin
                    w_state_n = SEARCH;
                    w_good_n  = '0;
                end else if (w_line_err || w_frame_err) begin
                    w_state_n = TRACK;
                    w_good_n  = '0;
                end
            end
            default: begin
                w_state_n = SEARCH;
                w_good_n  = '0;
            end
        endcase
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEARCH;
            r_good  <= '0;
            r_bad   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_good  <= w_good_n;
            r_bad   <= w_fstart ? 1'b0 : w_bad_n;
        end
    end

    assign w_lock_n = (w_state_n == LOCKED);
    assign w_hvis   = (w_hpos >= H_VIS0) && (w_hpos < H_VIS1);
    assign w_vvis   = (w_vpos >= V_VIS0) && (w_vpos < V_VIS1);
    assign w_pix_n  = w_lock_n & w_hvis & w_vvis;
    assign w_px     = w_hpos[9:0] - H_X0;
    assign w_py     = w_vpos - V_VIS0;

    assign w_err_inc = {1'b0, w_line_err} + {1'b0, w_frame_err};
    assign w_err_sum = {1'b0, r_err} + {7'd0, w_err_inc};

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked    <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_x     <= 10'd0;
            r_pix_y     <= 10'd0;
            r_pix_rgb   <= 3'd0;
            r_line_err  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err       <= 8'd0;
        end else begin
            r_locked    <= w_lock_n;
            r_pix_valid <= w_pix_n;
            r_line_err  <= w_line_err;
            r_frame_err <= w_frame_err;
            r_err       <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
            if (w_pix_n) begin
                r_pix_x   <= w_px;
                r_pix_y   <= w_py;
                r_pix_rgb <= r_rgb;
            end
        end
    end

    assign locked    = r_locked;
    assign pix_valid = r_pix_valid;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign pix_rgb   = r_pix_rgb;
    assign line_err  = r_line_err;
    assign frame_err = r_frame_err;
    assign err_count = r_err;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a scaled-down raster (16x10 lines) so
// lock, pixel, watchdog and saturation scenarios fit in a short run.
module tb_vga_sync_receiver;

    localparam int HS = 3;
    localparam int HB = 2;
    localparam int HA = 8;
    localparam int HT = 16;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VA = 4;
    localparam int VT = 10;
    localparam int LF = 2;

    logic       vga_clk = 1'b0;
    logic       rst_n   = 1'b1;
    logic [2:0] rgb_in  = 3'd0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       locked;
    logic       pix_valid;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [2:0] pix_rgb;
    logic       line_err;
    logic       frame_err;
    logic [7:0] err_count;

    vga_sync_receiver #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
        .LOCK_FRAMES(LF)
    ) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .rgb_in(rgb_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .locked(locked), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .line_err(line_err), .frame_err(frame_err),
        .err_count(err_count)
    );

    always #20 vga_clk = ~vga_clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t sb_q[$];
    pix_t first_p;
    pix_t last_p;
    bit   push_en = 1'b0;
    bit   sb_on   = 1'b0;
    bit   lock_seen = 1'b0;
    int   n_pop = 0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   le_cnt = 0;
    int   fe_cnt = 0;
    int   fe_cyc = 0;
    int   fall_cyc = 0;

    always @(posedge vga_clk) cyc <= cyc + 1;

    always @(negedge vga_clk) begin
        if (rst_n) begin
            if (line_err) le_cnt++;
            if (frame_err) begin
                fe_cnt++;
                fe_cyc = cyc;
            end
            if (locked) lock_seen = 1'b1;
            if (line_err || frame_err) begin
                checks++;
                if (locked !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_drop: locked=%0b with error pulse", locked);
                end
            end
            if (pix_valid) begin
                checks++;
                if (locked !== 1'b1) begin
                    errors++;
                    $display("FAIL valid_unlocked: pix_valid=1 locked=%0b", locked);
                end
            end
            if (sb_on && pix_valid) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_pixel: got (%0d,%0d) none expected", pix_x, pix_y);
                end else begin
                    pix_t e;
                    pix_t a;
                    e = sb_q.pop_front();
                    a = '{x: pix_x, y: pix_y, c: pix_rgb};
                    if (n_pop == 0) first_p = a;
                    last_p = a;
                    n_pop++;
                    if (a !== e) begin
                        errors++;
                        $display("FAIL pixel: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                                 a.x, a.y, a.c, e.x, e.y, e.c);
                    end
                end
            end
        end
    end

    task automatic drive(input logic h, input logic v, input logic [2:0] c);
        hsync_in = h;
        vsync_in = v;
        rgb_in   = c;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b1, 3'd0);
    endtask

    task automatic send_seg(input int v, input int vsw, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) begin
            logic [2:0] c;
            c = 3'($urandom_range(7));
            if (push_en && h >= HS + HB && h < HS + HB + HA &&
                v >= VS + VB && v < VS + VB + VA)
                sb_q.push_back('{x: 10'(h - HS - HB), y: 10'(v - VS - VB), c: c});
            drive(h >= HS, v >= vsw, c);
            if (h == 0) fall_cyc = cyc;
        end
    endtask

    task automatic send_frame(input int vsw, input int short_line);
        for (int v = 0; v < VT; v++)
            send_seg(v, vsw, 0, (v == short_line) ? HT - 2 : HT - 1);
    endtask

    // Two clean frames already sent; locked must rise exactly one cycle
    // after the third frame-start sample is captured.
    task automatic lock_edge_frame();
        send_seg(0, VS, 0, 0);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early: locked=%0b expected 0", locked);
        end
        send_seg(0, VS, 1, 1);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_rise: locked=%0b expected 1", locked);
        end
        send_seg(0, VS, 2, HT - 1);
        for (int v = 1; v < VT; v++) send_seg(v, VS, 0, HT - 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #5 rst_n = 1'b0;
        idle(3);
        checks++;
        if ({locked, pix_valid, pix_x, pix_y, pix_rgb, line_err, frame_err, err_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: locked=%0b valid=%0b err_count=%0d", locked, pix_valid, err_count);
        end
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_lock_acquire();
        int le0;
        int fe0;
        le0 = le_cnt;
        fe0 = fe_cnt;
        send_frame(VS, -1);
        send_frame(VS, -1);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_two_frames: locked=%0b expected 0", locked);
        end
        lock_edge_frame();
        checks++;
        if (err_count !== 8'd0) begin
            errors++;
            $display("FAIL acquire_err_count: got %0d expected 0", err_count);
        end
        checks++;
        if (le_cnt - le0 != 0 || fe_cnt - fe0 != 0) begin
            errors++;
            $display("FAIL acquire_pulses: line=%0d frame=%0d expected 0", le_cnt - le0, fe_cnt - fe0);
        end
    endtask

    task automatic test_pixels();
        sb_q.delete();
        n_pop   = 0;
        push_en = 1'b1;
        sb_on   = 1'b1;
        send_frame(VS, -1);
        push_en = 1'b0;
        sb_on   = 1'b0;
        checks++;
        if (n_pop != HA * VA) begin
            errors++;
            $display("FAIL pixel_count: got %0d expected %0d", n_pop, HA * VA);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL pixel_missing: %0d left expected 0", sb_q.size());
        end
        checks++;
        if (first_p.x !== 10'd0 || first_p.y !== 10'd0) begin
            errors++;
            $display("FAIL first_pixel: got (%0d,%0d) expected (0,0)", first_p.x, first_p.y);
        end
        checks++;
        if (last_p.x !== 10'(HA - 1) || last_p.y !== 10'(VA - 1)) begin
            errors++;
            $display("FAIL last_pixel: got (%0d,%0d) expected (%0d,%0d)", last_p.x, last_p.y, HA - 1, VA - 1);
        end
    endtask

    task automatic test_short_line();
        int le0;
        le0 = le_cnt;
        send_frame(VS, 5);
        checks++;
        if (le_cnt - le0 != 1) begin
            errors++;
            $display("FAIL short_line_pulses: got %0d expected 1", le_cnt - le0);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL short_line_unlock: locked=%0b expected 0", locked);
        end
        checks++;
        if (err_count !== 8'd1) begin
            errors++;
            $display("FAIL short_line_count: got %0d expected 1", err_count);
        end
        send_frame(VS, -1);
        send_frame(VS, -1);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL relock_early: locked=%0b expected 0", locked);
        end
        lock_edge_frame();
    endtask

    task automatic test_watchdog();
        int fe0;
        int le0;
        int exp_cyc;
        fe0 = fe_cnt;
        le0 = le_cnt;
        exp_cyc = fall_cyc + 1 + 2 * HT;
        idle(3 * HT);
        checks++;
        if (fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL watchdog_pulses: got %0d expected 1", fe_cnt - fe0);
        end
        checks++;
        if (fe_cyc != exp_cyc) begin
            errors++;
            $display("FAIL watchdog_time: got cycle %0d expected %0d", fe_cyc, exp_cyc);
        end
        checks++;
        if (locked !== 1'b0 || le_cnt != le0) begin
            errors++;
            $display("FAIL watchdog_state: locked=%0b line=%0d expected 0,0", locked, le_cnt - le0);
        end
        checks++;
        if (err_count !== 8'd2) begin
            errors++;
            $display("FAIL watchdog_count: got %0d expected 2", err_count);
        end
    endtask

    task automatic test_vsync_width();
        int fe0;
        int le0;
        fe0 = fe_cnt;
        le0 = le_cnt;
        lock_seen = 1'b0;
        for (int f = 0; f < 300; f++) send_frame(VS + 1, -1);
        checks++;
        if (fe_cnt - fe0 != 299) begin
            errors++;
            $display("FAIL vsync_pulses: got %0d expected 299", fe_cnt - fe0);
        end
        checks++;
        if (lock_seen !== 1'b0 || le_cnt != le0) begin
            errors++;
            $display("FAIL vsync_lock: lock_seen=%0b line=%0d expected 0,0", lock_seen, le_cnt - le0);
        end
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL err_saturate: got %0d expected 255", err_count);
        end
    endtask

    task automatic test_reset_midline();
        for (int f = 0; f < 4; f++) send_frame(VS, -1);
        for (int v = 0; v < 5; v++) send_seg(v, VS, 0, HT - 1);
        send_seg(5, VS, 0, 8);
        checks++;
        if (locked !== 1'b1 || pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: locked=%0b valid=%0b expected 1,1", locked, pix_valid);
        end
        #5 rst_n = 1'b0;
        #1;
        checks++;
        if ({locked, pix_valid, pix_x, pix_y, pix_rgb, line_err, frame_err, err_count} !== '0) begin
            errors++;
            $display("FAIL async_reset: locked=%0b valid=%0b x=%0d y=%0d err_count=%0d",
                     locked, pix_valid, pix_x, pix_y, err_count);
        end
        @(posedge vga_clk);
        #1;
        idle(3);
        rst_n = 1'b1;
        idle(4);
        test_lock_acquire();
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_pixels();
        test_short_line();
        test_watchdog();
        test_vsync_width();
        test_reset_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
